load_use_stall_ctrl: RTL and testbench
======================================

Name: load_use_stall_ctrl

Overview:
- Sequential hazard controller directly upstream of forwarding_unit; produces the stall, load-use-stall and AMO phase signals it consumes.
- Detects load-use and AMO-use RAW hazards between EX (producer) and ID (consumer).
- Sequences the multi-cycle AMO read/modify/write, and holds the pipeline until memory data is capturable for forwarding.

Parameters:
- REG_ADDR_WIDTH, 5, width of architectural register indices.
- PERF_CNT_WIDTH, 32, width of optional stall counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_flush  in  1  pipeline flush (branch/trap); synchronous abort of any sequence
- i_ex_valid  in  1  EX holds a valid instruction
- i_ex_is_load  in  1  EX instruction is a load
- i_ex_is_amo  in  1  EX instruction is an AMO (incl. LR/SC)
- i_ex_dest_reg  in  REG_ADDR_WIDTH  EX rd
- i_id_source_reg_1  in  REG_ADDR_WIDTH  ID rs1 (early, from PD)
- i_id_source_reg_2  in  REG_ADDR_WIDTH  ID rs2 (early, from PD)
- i_id_uses_rs1  in  1  ID instruction reads rs1
- i_id_uses_rs2  in  1  ID instruction reads rs2
- i_cache_hit_on_load  in  1  L0 hit for the EX load; data forwardable with 0 stall
- i_mem_read_valid  in  1  MA memory read data valid this cycle
- o_stall  out  1  freeze PC..EX registers
- o_stall_for_load_use_hazard  out  1  forwarding unit captures MA memory data this cycle
- o_amo_read_phase  out  1  AMO waiting for/receiving old memory value
- o_amo_write_enable  out  1  AMO result write-back strobe
- o_load_use_stall_count  out  PERF_CNT_WIDTH  optional counter (0 when feature off)
- o_amo_stall_count  out  PERF_CNT_WIDTH  optional counter (0 when feature off)

Behaviour:
- Reset (async, i_rst=1): state=IDLE; all outputs 0; counters 0.
- Hazard term: hz = i_ex_valid & i_ex_dest_reg!=0 & ((i_id_uses_rs1 & rd==rs1) | (i_id_uses_rs2 & rd==rs2)).
- States: IDLE, LOAD_WAIT, AMO_READ, AMO_WRITE (2-bit encoding).
- IDLE:
  - i_ex_is_amo & i_ex_valid -> AMO_READ (AMO always serialises, regardless of hz).
  - else i_ex_is_load & hz & ~i_cache_hit_on_load -> LOAD_WAIT.
  - else stay. All outputs combinationally 0 in IDLE (no stall is generated on the detection cycle itself; the stall begins the next cycle, matching registered forward controls).
- LOAD_WAIT:
  - o_stall=1.
  - On i_mem_read_valid: o_stall_for_load_use_hazard=1 for exactly that cycle, then -> IDLE.
  - Otherwise hold; unbounded wait.
- AMO_READ:
  - o_stall=1, o_amo_read_phase=1.
  - On i_mem_read_valid: o_stall_for_load_use_hazard=1, then -> AMO_WRITE.
- AMO_WRITE:
  - o_stall=1, o_amo_write_enable=1 for exactly one cycle, then -> IDLE.
- Latency: load-use costs 1 stall cycle when memory returns on the first wait cycle; an AMO costs at least 2 stall cycles.
- i_flush (sync):
  - Forces the next state to IDLE from any state.
  - Suppresses o_stall_for_load_use_hazard and o_amo_write_enable in the flush cycle.
  - Exception: AMO_WRITE with flush still completes its write, because the memory side effect is committed. Flush only blocks new entry from IDLE.
- Simultaneous flush and i_mem_read_valid in AMO_READ: abort; no write strobe.
- Reset asserted mid-sequence: immediate return to IDLE, outputs 0; any in-flight memory response after reset is ignored.
- Register index comparisons are unsigned equality; x0 is never a hazard.

Optional Feature:
- Macro: LOAD_USE_STALL_PERF_CNT_EN.
- Defined:
  - o_load_use_stall_count increments on every cycle in LOAD_WAIT.
  - o_amo_stall_count increments on every cycle in AMO_READ or AMO_WRITE.
  - Both counters saturate at all-ones (no wrap) and clear on i_rst.
- Undefined: both outputs tied to 0; no counter flops are synthesised.

Decomposition:
- riscv_pkg gains typedef enum logic [1:0] hazard_state_e {HZ_IDLE, HZ_LOAD_WAIT, HZ_AMO_READ, HZ_AMO_WRITE}, plus a localparam HZ_STATE_WIDTH=2.
- One natural sub-module: sat_counter (parameterised width, increment, async clear), instantiated twice under the macro.
- Hazard compare stays inline.

Test Plan:
- Load x5 in EX, ID reads rs1=x5, cache miss, i_mem_read_valid on the 1st wait cycle -> o_stall=1 for 1 cycle; o_stall_for_load_use_hazard pulses in the same cycle; back to IDLE.
- Same as above but i_cache_hit_on_load=1 -> no stall; outputs stay 0.
- Load writing rd=x0 with ID rs2=x0 -> no stall.
- AMO in EX, i_mem_read_valid after 3 cycles -> o_amo_read_phase=1 for 3 cycles with o_stall_for_load_use_hazard on the 3rd; then o_amo_write_enable=1 for 1 cycle; total 4 stall cycles.
- AMO_READ with i_flush together with i_mem_read_valid -> no write strobe; IDLE next cycle. Flush during AMO_WRITE -> write strobe still 1.
- i_rst asserted asynchronously mid-LOAD_WAIT -> all outputs 0 before the next edge. With LOAD_USE_STALL_PERF_CNT_EN and PERF_CNT_WIDTH=4, 20 LOAD_WAIT cycles -> count saturates at 15.

Source files
------------

// File: rtl/load_use_stall_ctrl_pkg.sv
// Shared types for the load/AMO-use hazard controller: the 2-bit hazard
// sequencer state and its encoding width.
package load_use_stall_ctrl_pkg;

  localparam int HZ_STATE_WIDTH = 2;

  typedef enum logic [HZ_STATE_WIDTH-1:0] {
    HZ_IDLE       = 2'd0,
    HZ_LOAD_WAIT  = 2'd1,
    HZ_AMO_READ   = 2'd2,
    HZ_AMO_WRITE  = 2'd3
  } hazard_state_e;

endpackage

// File: rtl/load_use_stall_ctrl_sat_counter.sv
// sat_counter: unsigned up-counter that sticks at all-ones, async clear.
// Used for the optional stall performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/load_use_stall_ctrl.sv
// Load-use / AMO-use hazard sequencer feeding the forwarding unit.
// Optional stall counters enabled by defining LOAD_USE_STALL_PERF_CNT_EN.
module load_use_stall_ctrl
  import load_use_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic                      i_ex_valid,
  input  logic                      i_ex_is_load,
  input  logic                      i_ex_is_amo,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_dest_reg,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_source_reg_1,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_source_reg_2,
  input  logic                      i_id_uses_rs1,
  input  logic                      i_id_uses_rs2,
  input  logic                      i_cache_hit_on_load,
  input  logic                      i_mem_read_valid,
  output logic                      o_stall,
  output logic                      o_stall_for_load_use_hazard,
  output logic                      o_amo_read_phase,
  output logic                      o_amo_write_enable,
  output logic [PERF_CNT_WIDTH-1:0] o_load_use_stall_count,
  output logic [PERF_CNT_WIDTH-1:0] o_amo_stall_count
);

  hazard_state_e r_state;
  hazard_state_e w_next_state;
  logic          w_hazard;

  // x0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign w_hazard = i_ex_valid && (i_ex_dest_reg != '0) &&
                    ((i_id_uses_rs1 && (i_ex_dest_reg == i_id_source_reg_1)) ||
                     (i_id_uses_rs2 && (i_ex_dest_reg == i_id_source_reg_2)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= HZ_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HZ_IDLE: begin
        if (!i_flush) begin
          if (i_ex_valid && i_ex_is_amo) begin
            w_next_state = HZ_AMO_READ;
          end else if (i_ex_is_load && w_hazard && !i_cache_hit_on_load) begin
            w_next_state = HZ_LOAD_WAIT;
          end
        end
      end
      HZ_LOAD_WAIT: begin
        if (i_flush || i_mem_read_valid) w_next_state = HZ_IDLE;
      end
      HZ_AMO_READ: begin
        if (i_flush)               w_next_state = HZ_IDLE;
        else if (i_mem_read_valid) w_next_state = HZ_AMO_WRITE;
      end
      HZ_AMO_WRITE: w_next_state = HZ_IDLE;
      default:      w_next_state = HZ_IDLE;
    endcase
  end

  // The write strobe ignores flush: by AMO_WRITE the memory side effect is committed.
  always_comb begin
    o_stall                     = 1'b0;
    o_stall_for_load_use_hazard = 1'b0;
    o_amo_read_phase            = 1'b0;
    o_amo_write_enable          = 1'b0;
    case (r_state)
      HZ_LOAD_WAIT: begin
        o_stall                     = 1'b1;
        o_stall_for_load_use_hazard = i_mem_read_valid && !i_flush;
      end
      HZ_AMO_READ: begin
        o_stall                     = 1'b1;
        o_amo_read_phase            = 1'b1;
        o_stall_for_load_use_hazard = i_mem_read_valid && !i_flush;
      end
      HZ_AMO_WRITE: begin
        o_stall            = 1'b1;
        o_amo_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef LOAD_USE_STALL_PERF_CNT_EN
  logic w_inc_load_use;
  logic w_inc_amo;

  assign w_inc_load_use = (r_state == HZ_LOAD_WAIT);
  assign w_inc_amo      = (r_state == HZ_AMO_READ) || (r_state == HZ_AMO_WRITE);

  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_load_use_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_inc_load_use),
    .o_count (o_load_use_stall_count)
  );

  sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_amo_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_inc_amo),
    .o_count (o_amo_stall_count)
  );
`else
  assign o_load_use_stall_count = '0;
  assign o_amo_stall_count      = '0;
`endif

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Scoreboard bench for load_use_stall_ctrl: expected outputs are queued per
// driven cycle and popped when the outputs are sampled mid-cycle.
module tb_load_use_stall_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;
`ifdef LOAD_USE_STALL_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic          ex_valid;
    logic          ex_is_load;
    logic          ex_is_amo;
    logic [RW-1:0] ex_rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          uses1;
    logic          uses2;
    logic          hit;
    logic          mrv;
    logic          flush;
  } in_t;

  // Expected output vector: {stall, load_use_capture, amo_read, amo_write}
  localparam logic [3:0] E_NONE = 4'b0000;
  localparam logic [3:0] E_LW   = 4'b1000;
  localparam logic [3:0] E_LWC  = 4'b1100;
  localparam logic [3:0] E_LWF  = 4'b1000;
  localparam logic [3:0] E_AR   = 4'b1010;
  localparam logic [3:0] E_ARC  = 4'b1110;
  localparam logic [3:0] E_AW   = 4'b1001;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, ex_valid, ex_is_load, ex_is_amo;
  logic [RW-1:0] ex_rd, rs1, rs2;
  logic          uses1, uses2, hit, mrv;
  logic          stall, lu_cap, amo_rd, amo_we;
  logic [CW-1:0] lu_cnt, amo_cnt;

  int            total = 0;
  int            bad   = 0;
  logic [3:0]    exp_q[$];
  logic [CW-1:0] m_lu  = '0;
  logic [CW-1:0] m_amo = '0;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(
    .REG_ADDR_WIDTH (RW),
    .PERF_CNT_WIDTH (CW)
  ) dut (
    .i_clk                       (clk),
    .i_rst                       (rst),
    .i_flush                     (flush),
    .i_ex_valid                  (ex_valid),
    .i_ex_is_load                (ex_is_load),
    .i_ex_is_amo                 (ex_is_amo),
    .i_ex_dest_reg               (ex_rd),
    .i_id_source_reg_1           (rs1),
    .i_id_source_reg_2           (rs2),
    .i_id_uses_rs1               (uses1),
    .i_id_uses_rs2               (uses2),
    .i_cache_hit_on_load         (hit),
    .i_mem_read_valid            (mrv),
    .o_stall                     (stall),
    .o_stall_for_load_use_hazard (lu_cap),
    .o_amo_read_phase            (amo_rd),
    .o_amo_write_enable          (amo_we),
    .o_load_use_stall_count      (lu_cnt),
    .o_amo_stall_count           (amo_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic in_t nop_in(input logic m, input logic f);
    in_t t = '0;
    t.mrv   = m;
    t.flush = f;
    return t;
  endfunction

  function automatic in_t ld_in(input logic [RW-1:0] rd, input logic [RW-1:0] s1,
                                input logic [RW-1:0] s2, input logic u1, input logic u2,
                                input logic h, input logic f);
    in_t t = '0;
    t.ex_valid = 1'b1; t.ex_is_load = 1'b1; t.ex_rd = rd;
    t.rs1 = s1; t.rs2 = s2; t.uses1 = u1; t.uses2 = u2; t.hit = h; t.flush = f;
    return t;
  endfunction

  function automatic in_t amo_in(input logic f);
    in_t t = '0;
    t.ex_valid = 1'b1; t.ex_is_amo = 1'b1; t.ex_rd = 5'd9; t.flush = f;
    return t;
  endfunction

  task automatic apply(input in_t t);
    ex_valid = t.ex_valid; ex_is_load = t.ex_is_load; ex_is_amo = t.ex_is_amo;
    ex_rd = t.ex_rd; rs1 = t.rs1; rs2 = t.rs2; uses1 = t.uses1; uses2 = t.uses2;
    hit = t.hit; mrv = t.mrv; flush = t.flush;
  endtask

  // Pop one expectation and compare; counters reflect cycles already completed.
  task automatic compare_out(input string tag);
    logic [3:0] want;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    want = exp_q.pop_front();
    check(tag, {28'd0, stall, lu_cap, amo_rd, amo_we}, {28'd0, want});
    check({tag, "_lu_cnt"}, 32'(lu_cnt), CNT_EN ? 32'(m_lu) : 32'd0);
    check({tag, "_amo_cnt"}, 32'(amo_cnt), CNT_EN ? 32'(m_amo) : 32'd0);
    if (want[3] && !want[1] && !want[0] && m_lu != '1)   m_lu++;
    if ((want[1] || want[0]) && m_amo != '1)              m_amo++;
  endtask

  task automatic cyc(input string tag, input in_t t, input logic [3:0] e);
    @(negedge clk);
    apply(t);
    exp_q.push_back(e);
    #2;
    compare_out(tag);
  endtask

  initial begin
    rst = 1'b1;
    apply(nop_in(1'b0, 1'b0));
    #3;
    check("reset_outs", {28'd0, stall, lu_cap, amo_rd, amo_we}, 32'd0);
    check("reset_lu_cnt", 32'(lu_cnt), 32'd0);
    check("reset_amo_cnt", 32'(amo_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use, data back on the first wait cycle
    cyc("lu_detect", ld_in(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_NONE);
    cyc("lu_wait1",  nop_in(1'b1, 1'b0), E_LWC);
    cyc("lu_done",   nop_in(1'b0, 1'b0), E_NONE);

    // Cache hit: no stall
    cyc("hit_detect", ld_in(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), E_NONE);
    cyc("hit_after",  nop_in(1'b0, 1'b0), E_NONE);

    // x0 destination never hazards
    cyc("x0_detect", ld_in(5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), E_NONE);
    cyc("x0_after",  nop_in(1'b0, 1'b0), E_NONE);

    // Matching register but rs1 unused: no hazard
    cyc("nouse_detect", ld_in(5'd7, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0), E_NONE);
    cyc("nouse_after",  nop_in(1'b0, 1'b0), E_NONE);

    // rs2 hazard with a two-cycle memory wait
    cyc("rs2_detect", ld_in(5'd31, 5'd1, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0), E_NONE);
    cyc("rs2_wait1",  nop_in(1'b0, 1'b0), E_LW);
    cyc("rs2_wait2",  nop_in(1'b0, 1'b0), E_LW);
    cyc("rs2_cap",    nop_in(1'b1, 1'b0), E_LWC);
    cyc("rs2_done",   nop_in(1'b0, 1'b0), E_NONE);

    // AMO: memory returns on the third read cycle
    cyc("amo_detect", amo_in(1'b0), E_NONE);
    cyc("amo_rd1",    nop_in(1'b0, 1'b0), E_AR);
    cyc("amo_rd2",    nop_in(1'b0, 1'b0), E_AR);
    cyc("amo_rd3",    nop_in(1'b1, 1'b0), E_ARC);
    cyc("amo_wr",     nop_in(1'b0, 1'b0), E_AW);
    cyc("amo_done",   nop_in(1'b0, 1'b0), E_NONE);

    // Flush together with read data aborts the AMO
    cyc("amof_detect", amo_in(1'b0), E_NONE);
    cyc("amof_rd1",    nop_in(1'b0, 1'b0), E_AR);
    cyc("amof_abort",  nop_in(1'b1, 1'b1), E_AR);
    cyc("amof_idle",   nop_in(1'b0, 1'b0), E_NONE);

    // Flush during AMO_WRITE still strobes the write
    cyc("amow_detect", amo_in(1'b0), E_NONE);
    cyc("amow_rd",     nop_in(1'b1, 1'b0), E_ARC);
    cyc("amow_wr",     nop_in(1'b0, 1'b1), E_AW);
    cyc("amow_idle",   nop_in(1'b0, 1'b0), E_NONE);

    // Flush blocks entry from IDLE
    cyc("fl_ld",      ld_in(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), E_NONE);
    cyc("fl_ld_next", nop_in(1'b1, 1'b0), E_NONE);
    cyc("fl_amo",     amo_in(1'b1), E_NONE);
    cyc("fl_amo_next", nop_in(1'b1, 1'b0), E_NONE);

    // Flush in LOAD_WAIT with data: capture suppressed, back to IDLE
    cyc("lwf_detect", ld_in(5'd12, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_NONE);
    cyc("lwf_flush",  nop_in(1'b1, 1'b1), E_LWF);
    cyc("lwf_idle",   nop_in(1'b0, 1'b0), E_NONE);

    // Async reset mid LOAD_WAIT
    cyc("rst_detect", ld_in(5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0), E_NONE);
    cyc("rst_wait",   nop_in(1'b0, 1'b0), E_LW);
    @(negedge clk);
    apply(nop_in(1'b0, 1'b0));
    #1;
    check("rst_pre", {28'd0, stall, lu_cap, amo_rd, amo_we}, {28'd0, E_LW});
    rst = 1'b1;
    #1;
    m_lu  = '0;
    m_amo = '0;
    check("rst_async_outs", {28'd0, stall, lu_cap, amo_rd, amo_we}, 32'd0);
    check("rst_async_lu_cnt", 32'(lu_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("rst_late_data", nop_in(1'b1, 1'b0), E_NONE);

    // Long LOAD_WAIT: counter saturation
    cyc("sat_detect", ld_in(5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), E_NONE);
    for (int i = 0; i < 20; i++) cyc("sat_wait", nop_in(1'b0, 1'b0), E_LW);
    cyc("sat_cap",  nop_in(1'b1, 1'b0), E_LWC);
    cyc("sat_done", nop_in(1'b0, 1'b0), E_NONE);
    check("sat_value", 32'(lu_cnt), CNT_EN ? 32'd15 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
